// File: rtl/cva6v_rvfi_pkg.sv
// Shared RVFI types: order number and default packed rvfi_instr_t record width.
// Combinational definitions only; no latency or backpressure of its own.
package cva6v_rvfi_pkg;

    typedef logic [63:0] rvfi_order_t;

    localparam int unsigned RvfiRecWDefault = 512;

endpackage

// File: rtl/cva6v_rvfi_compact.sv
// Packs sparse valid lanes into dense lanes in ascending port order and reports their count.
// Purely combinational (zero latency); no backpressure, lanes at or above dense_cnt are zero.
module cva6v_rvfi_compact #(
    parameter int unsigned NrPorts = 2,
    parameter int unsigned W       = 512
) (
    input  logic [NrPorts-1:0]           lane_valid,
    input  logic [NrPorts*W-1:0]         lane_rec,
    output logic [NrPorts*W-1:0]         dense_rec,
    output logic [$clog2(NrPorts+1)-1:0] dense_cnt
);

    localparam int unsigned CW = $clog2(NrPorts + 1);

    always_comb begin
        int unsigned k;
        k         = 0;
        dense_rec = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            if (lane_valid[i]) begin
                dense_rec[k*W +: W] = lane_rec[i*W +: W];
                k++;
            end
        end
        dense_cnt = CW'(k);
    end

endmodule

// File: rtl/cva6v_rvfi_retire_queue.sv
// Retirement FIFO: compacts and order-stamps up to NrInPorts records/cycle, drains NrOutPorts/cycle.
// Records visible one cycle after push; when short of NrInPorts free slots whole groups are dropped and counted.
module cva6v_rvfi_retire_queue
    import cva6v_rvfi_pkg::*;
#(
    parameter int unsigned NrInPorts  = 2,
    parameter int unsigned NrOutPorts = 1,
    parameter int unsigned Depth      = 16,
    parameter int unsigned RecW       = RvfiRecWDefault,
    parameter int unsigned CntW       = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [NrInPorts-1:0]       in_valid_i,
    input  logic [NrInPorts*RecW-1:0]  in_rec_i,
    output logic                       in_ready_o,
    output logic [NrOutPorts-1:0]      out_valid_o,
    output logic [NrOutPorts*RecW-1:0] out_rec_o,
    output logic [NrOutPorts*64-1:0]   out_order_o,
    input  logic                       out_ready_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       overflow_o,
    output logic [CntW-1:0]            drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned PW   = $clog2(NrInPorts + 1);

    logic [NrInPorts*RecW-1:0] dense_rec;
    logic [PW-1:0]             push_cnt;
    logic [RecW-1:0]           mem_rec   [Depth];
    rvfi_order_t               mem_order [Depth];
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]           count_q, push_acc, pop_cnt;
    rvfi_order_t               order_q;
    logic                      overflow_q;
    logic [CntW-1:0]           drop_cnt_q;
    logic [CntW:0]             drop_sum;
    logic                      push_en, drop_en;

    cva6v_rvfi_compact #(
        .NrPorts (NrInPorts),
        .W       (RecW)
    ) i_compact (
        .lane_valid (in_valid_i),
        .lane_rec   (in_rec_i),
        .dense_rec  (dense_rec),
        .dense_cnt  (push_cnt)
    );

    // Ready comes from the registered count only, so a same-cycle pop never frees room for a push.
    assign in_ready_o = count_q <= OccW'(Depth - NrInPorts);
    assign push_en    = in_ready_o && (push_cnt != '0) && !clear_i;
    assign drop_en    = !in_ready_o && (push_cnt != '0) && !clear_i;
    assign push_acc   = push_en ? OccW'(push_cnt) : '0;
    assign pop_cnt    = !out_ready_i ? '0 :
                        (count_q > OccW'(NrOutPorts)) ? OccW'(NrOutPorts) : count_q;
    assign drop_sum   = {1'b0, drop_cnt_q} + (CntW+1)'(push_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrW'(push_acc);
            rd_ptr_q <= rd_ptr_q + PtrW'(pop_cnt);
            count_q  <= count_q + push_acc - pop_cnt;
            order_q  <= order_q + rvfi_order_t'(push_acc);
            if (drop_en) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[CntW] ? '1 : drop_sum[CntW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_rec[PtrW'(i)]   <= '0;
                mem_order[PtrW'(i)] <= '0;
            end
        end else if (push_en) begin
            for (int unsigned j = 0; j < NrInPorts; j++) begin
                if (PW'(j) < push_cnt) begin
                    mem_rec[wr_ptr_q + PtrW'(j)]   <= dense_rec[j*RecW +: RecW];
                    mem_order[wr_ptr_q + PtrW'(j)] <= order_q + rvfi_order_t'(j);
                end
            end
        end
    end

    for (genvar k = 0; k < NrOutPorts; k++) begin : g_out
        logic [PtrW-1:0] idx;
        assign idx                          = rd_ptr_q + PtrW'(k);
        assign out_valid_o[k]               = count_q > OccW'(k);
        assign out_rec_o[k*RecW +: RecW]    = mem_rec[idx];
        assign out_order_o[k*64 +: 64]      = mem_order[idx];
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i)
        ((Depth & (Depth - 1)) == 0) && (NrOutPorts <= NrInPorts));
    a_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= OccW'(Depth));
    a_thermo: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o & (out_valid_o + 1'b1)) == '0);
`endif

endmodule
